// File: rtl/hw_pkg.sv
// Shared definitions for the four-way stream demultiplexer.
//   NumLanes      : number of output lanes
//   SelA..SelD    : lane-select encodings carried on sel
//   lane_state_e  : per-lane holding register state
//   sel_decode()  : one-hot lane decode of a select value
package hw_pkg;

  localparam int unsigned NumLanes = 4;

  localparam logic [1:0] SelA = 2'd0;
  localparam logic [1:0] SelB = 2'd1;
  localparam logic [1:0] SelC = 2'd2;
  localparam logic [1:0] SelD = 2'd3;

  typedef enum logic {
    LaneEmpty,
    LaneFull
  } lane_state_e;

  function automatic logic [NumLanes-1:0] sel_decode(input logic [1:0] sel);
    logic [NumLanes-1:0] onehot;
    onehot = '0;
    unique case (sel)
      SelA:    onehot = 4'b0001;
      SelB:    onehot = 4'b0010;
      SelC:    onehot = 4'b0100;
      SelD:    onehot = 4'b1000;
      default: onehot = '0;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/demux4way16_stream_if.sv
// Stream bus for demux4way16_stream: one input stream, four output lanes, plus busy.
//   master : producer/consumers side (drives in/sel/in_valid and ready_a..ready_d)
//   slave  : the demultiplexer (drives in_ready, out_a..out_d, valid_a..valid_d, busy)
interface demux4way16_stream_if #(
  parameter int unsigned WIDTH = 16
);

  logic [WIDTH-1:0] in;
  logic [1:0]       sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_c;
  logic [WIDTH-1:0] out_d;
  logic             valid_a;
  logic             valid_b;
  logic             valid_c;
  logic             valid_d;
  logic             ready_a;
  logic             ready_b;
  logic             ready_c;
  logic             ready_d;

  logic             busy;

  modport master (
    output in, sel, in_valid,
    input  in_ready,
    input  out_a, out_b, out_c, out_d,
    input  valid_a, valid_b, valid_c, valid_d,
    output ready_a, ready_b, ready_c, ready_d,
    input  busy
  );

  modport slave (
    input  in, sel, in_valid,
    output in_ready,
    output out_a, out_b, out_c, out_d,
    output valid_a, valid_b, valid_c, valid_d,
    input  ready_a, ready_b, ready_c, ready_d,
    output busy
  );

endinterface

// File: rtl/demux_lane.sv
// One-entry holding register for a single output lane.
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset (lane EMPTY, data cleared)
//   load_i  : input transfer targets this lane this cycle
//   data_i  : word to capture on load
//   ready_i : lane consumer takes the held word this cycle
//   valid_o : lane holds an undelivered word
//   data_o  : held word (keeps last value while EMPTY)
module demux_lane
  import hw_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  lane_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load_i) begin
      // A load wins over a drain: simultaneous drain + load leaves the lane FULL with new data.
      state_d = LaneFull;
      data_d  = data_i;
    end else if (state_q == LaneFull && ready_i) begin
      state_d = LaneEmpty;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LaneEmpty;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = (state_q == LaneFull);
  assign data_o  = data_q;

endmodule

// File: rtl/demux4way16_stream.sv
// Four-way stream demultiplexer: routes each accepted word to the lane chosen by sel.
// Each lane is an independent one-entry holding register, so a stalled lane never
// blocks traffic to the others.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : stream bus (slave side) -- in/sel/in_valid/in_ready, out_x/valid_x/ready_x, busy
module demux4way16_stream
  import hw_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic                  clk,
  input logic                  reset,
  demux4way16_stream_if.slave  bus
);

  logic [NumLanes-1:0] lane_valid;
  logic [NumLanes-1:0] lane_ready;
  logic [NumLanes-1:0] lane_load;
  logic [WIDTH-1:0]    lane_data [NumLanes];
  logic                in_ready;

  assign lane_ready = {bus.ready_d, bus.ready_c, bus.ready_b, bus.ready_a};

  // in_ready looks only at the selected lane and never at in_valid.
  always_comb begin
    in_ready  = 1'b0;
    lane_load = '0;
    if (!reset) begin
      in_ready = !lane_valid[bus.sel] || lane_ready[bus.sel];
    end
    if (bus.in_valid && in_ready) begin
      lane_load = sel_decode(bus.sel);
    end
  end

  for (genvar g = 0; g < NumLanes; g++) begin : g_lane
    demux_lane #(
      .WIDTH (WIDTH)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .load_i  (lane_load[g]),
      .data_i  (bus.in),
      .ready_i (lane_ready[g]),
      .valid_o (lane_valid[g]),
      .data_o  (lane_data[g])
    );
  end

  assign bus.in_ready = in_ready;
  assign bus.out_a    = lane_data[SelA];
  assign bus.out_b    = lane_data[SelB];
  assign bus.out_c    = lane_data[SelC];
  assign bus.out_d    = lane_data[SelD];
  assign bus.valid_a  = lane_valid[SelA];
  assign bus.valid_b  = lane_valid[SelB];
  assign bus.valid_c  = lane_valid[SelC];
  assign bus.valid_d  = lane_valid[SelD];
  assign bus.busy     = |lane_valid;

endmodule

// File: tb/tb_demux4way16_stream.sv
// Directed self-checking bench for demux4way16_stream.
module tb_demux4way16_stream;
  import hw_pkg::*;

  logic clk;
  logic reset;
  int   nvec;
  int   nerr;

  demux4way16_stream_if #(.WIDTH(16)) bus ();

  demux4way16_stream #(
    .WIDTH (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [15:0] d);
    bus.in_valid = v;
    bus.sel      = s;
    bus.in       = d;
    #1;
  endtask

  function automatic logic [3:0] valids();
    return {bus.valid_d, bus.valid_c, bus.valid_b, bus.valid_a};
  endfunction

  task automatic set_ready(input logic [3:0] r);
    {bus.ready_d, bus.ready_c, bus.ready_b, bus.ready_a} = r;
    #1;
  endtask

  initial begin
    int          k;
    int          got;
    logic        accepted;
    logic [15:0] seen [8];

    nvec = 0;
    nerr = 0;
    reset = 1'b1;
    set_ready(4'b0000);
    drive(1'b0, SelA, 16'h0000);

    // Reset held for two cycles with in_valid low.
    check("in_ready_in_reset0", 32'(bus.in_ready), 32'h0);
    tick();
    tick();
    check("reset_valids", 32'(valids()), 32'h0);
    check("reset_out_a", 32'(bus.out_a), 32'h0);
    check("reset_out_b", 32'(bus.out_b), 32'h0);
    check("reset_out_c", 32'(bus.out_c), 32'h0);
    check("reset_out_d", 32'(bus.out_d), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("in_ready_in_reset1", 32'(bus.in_ready), 32'h0);
    reset = 1'b0;
    tick();

    // Four words to four lanes on consecutive cycles, all consumers ready.
    set_ready(4'b1111);
    drive(1'b1, SelA, 16'h1234);
    check("seq_rdy_a", 32'(bus.in_ready), 32'h1);
    tick();
    check("seq_valid_a", 32'(valids()), 32'b0001);
    check("seq_out_a", 32'(bus.out_a), 32'h1234);
    drive(1'b1, SelB, 16'h9876);
    check("seq_rdy_b", 32'(bus.in_ready), 32'h1);
    tick();
    check("seq_valid_b", 32'(valids()), 32'b0010);
    check("seq_out_b", 32'(bus.out_b), 32'h9876);
    drive(1'b1, SelC, 16'hAAAA);
    check("seq_rdy_c", 32'(bus.in_ready), 32'h1);
    tick();
    check("seq_valid_c", 32'(valids()), 32'b0100);
    check("seq_out_c", 32'(bus.out_c), 32'hAAAA);
    drive(1'b1, SelD, 16'h5555);
    check("seq_rdy_d", 32'(bus.in_ready), 32'h1);
    tick();
    check("seq_valid_d", 32'(valids()), 32'b1000);
    check("seq_out_d", 32'(bus.out_d), 32'h5555);
    check("seq_busy", 32'(bus.busy), 32'h1);
    drive(1'b0, SelA, 16'h0000);
    tick();
    check("seq_drained", 32'(valids()), 32'h0);
    check("seq_idle_busy", 32'(bus.busy), 32'h0);

    // Lane b backpressure.
    set_ready(4'b1101);
    drive(1'b1, SelB, 16'h9876);
    check("bp_rdy_first", 32'(bus.in_ready), 32'h1);
    tick();
    check("bp_out_b_first", 32'(bus.out_b), 32'h9876);
    drive(1'b1, SelB, 16'h1111);
    check("bp_stall", 32'(bus.in_ready), 32'h0);
    tick();
    check("bp_hold_out_b", 32'(bus.out_b), 32'h9876);
    check("bp_hold_valid", 32'(valids()), 32'b0010);
    check("bp_still_stall", 32'(bus.in_ready), 32'h0);
    set_ready(4'b1111);
    check("bp_release_rdy", 32'(bus.in_ready), 32'h1);
    tick();
    check("bp_out_b_second", 32'(bus.out_b), 32'h1111);
    check("bp_valid_second", 32'(valids()), 32'b0010);
    drive(1'b0, SelB, 16'h0000);
    tick();
    check("bp_drained", 32'(valids()), 32'h0);
    check("bp_out_b_held", 32'(bus.out_b), 32'h1111);

    // Stalled lane c does not block lane d.
    set_ready(4'b1011);
    drive(1'b1, SelC, 16'hAAAA);
    tick();
    check("iso_c_full", 32'(valids()), 32'b0100);
    drive(1'b1, SelD, 16'h5555);
    check("iso_rdy_d", 32'(bus.in_ready), 32'h1);
    drive(1'b1, SelC, 16'hAAAA);
    check("iso_rdy_c_blocked", 32'(bus.in_ready), 32'h0);
    drive(1'b1, SelD, 16'h5555);
    tick();
    check("iso_valid_cd", 32'(valids()), 32'b1100);
    check("iso_out_d", 32'(bus.out_d), 32'h5555);
    check("iso_out_c", 32'(bus.out_c), 32'hAAAA);
    drive(1'b0, SelA, 16'h0000);
    tick();
    check("iso_c_only", 32'(valids()), 32'b0100);
    set_ready(4'b1111);
    tick();
    check("iso_drained", 32'(valids()), 32'h0);

    // Mid-operation reset discards a held word.
    set_ready(4'b1110);
    drive(1'b1, SelA, 16'hAAAA);
    tick();
    check("rst_a_full", 32'(bus.out_a), 32'hAAAA);
    drive(1'b0, SelA, 16'h0000);
    reset = 1'b1;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    reset = 1'b0;
    #1;
    check("rst_valids", 32'(valids()), 32'h0);
    check("rst_out_a", 32'(bus.out_a), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    set_ready(4'b1111);
    drive(1'b1, SelA, 16'h1234);
    tick();
    check("post_rst_valid", 32'(valids()), 32'b0001);
    check("post_rst_out_a", 32'(bus.out_a), 32'h1234);
    drive(1'b0, SelA, 16'h0000);
    tick();

    // Back-to-back 0001..0008 to lane c with ready_c toggling each cycle.
    k   = 0;
    got = 0;
    for (int i = 0; i < 8; i++) seen[i] = 16'h0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      bus.ready_c = cyc[0];
      drive(k < 8, SelC, 16'(k + 1));
      if (bus.valid_c && bus.ready_c) begin
        if (got < 8) seen[got] = bus.out_c;
        got++;
      end
      accepted = bus.in_valid && bus.in_ready;
      tick();
      if (accepted) k++;
    end
    drive(1'b0, SelA, 16'h0000);
    check("b2b_accepted", 32'(k), 32'd8);
    check("b2b_delivered", 32'(got), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("b2b_word%0d", i), 32'(seen[i]), 32'(i + 1));
    end
    check("b2b_busy_end", 32'(bus.busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/demux4way16_stream.md
DEMUX4WAY16_STREAM -- requirements
Module: demux4way16_stream

Interface
REQ-001 Parameter WIDTH, default 16, is the data word width in bits.
REQ-002 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  is a synchronous, active-high reset.
REQ-004 in  input  WIDTH  is the word to be routed.
REQ-005 sel  input  2  is the destination lane: 00=a, 01=b, 10=c, 11=d.
REQ-006 in_valid  input  1  means in and sel are valid this cycle.
REQ-007 in_ready  output  1  means the block accepts in and sel this cycle.
REQ-008 out_a/out_b/out_c/out_d  output  WIDTH  are the lane data registers.
REQ-009 valid_a/valid_b/valid_c/valid_d  output  1  mean the corresponding lane holds an undelivered word.
REQ-010 ready_a/ready_b/ready_c/ready_d  input  1  mean the lane consumer takes the word this cycle.
REQ-011 busy  output  1  means at least one lane holds a word.

Function
REQ-012 Input transfer occurs on a cycle with in_valid=1 and in_ready=1; lane transfer x occurs on a cycle with valid_x=1 and ready_x=1.
REQ-013 Each lane is a one-entry holding register with two states: EMPTY (valid_x=0) and FULL (valid_x=1).
REQ-014 Transitions per lane x: EMPTY->FULL on input transfer with sel=x; FULL->EMPTY on lane transfer with no input transfer to x; FULL->FULL with new data on simultaneous lane transfer and input transfer to x; otherwise state holds.
REQ-015 in_ready is combinational: 1 when lane[sel] is EMPTY or ready_[sel]=1; it does not depend on in_valid.
REQ-016 in_ready ignores the state of unselected lanes; a FULL stalled lane never blocks traffic to other lanes.
REQ-017 Latency is one cycle: a word accepted at edge N appears on out_x with valid_x=1 after edge N.
REQ-018 out_x changes only on an input transfer to lane x; it holds its last value when EMPTY.
REQ-019 At most one lane is loaded per cycle; any number of lanes drain in the same cycle.
REQ-020 Words to the same lane are delivered in acceptance order; no word is duplicated or dropped.
REQ-021 A FULL lane with ready_x=0 holds out_x and valid_x stable until the transfer.
REQ-022 in_valid=0 leaves all lane states unchanged except drains; sel and in are don't-care then.
REQ-023 busy is the OR of valid_a..valid_d, taken from registered state.

Reset
REQ-024 While reset=1 at a rising edge, all lanes become EMPTY, out_a..out_d become 0, valid_a..valid_d become 0, and busy becomes 0.
REQ-025 While reset=1, in_ready reads 0 and no transfer is recorded.
REQ-026 Reset asserted mid-operation discards held words without delivering them; the first transfer after deassertion behaves as from power-up.

Structure
REQ-027 Lane-select encodings (SEL_A=0..SEL_D=3) and the lane-state enum (EMPTY, FULL) reside in the shared package hw_pkg.
REQ-028 One sub-module, demux_lane, implements a single holding register with load, drain and valid; the top instantiates it four times and decodes sel.
REQ-029 Top-level logic is limited to the sel decode, the in_ready mux and the busy OR.

Verification
REQ-030 Reset, then in_valid=0 for 2 cycles -> all valid_x=0, all out_x=16'h0000, busy=0, in_ready=0 while reset=1.
REQ-031 All ready_x=1; send 16'h1234/sel 00, 16'h9876/01, 16'hAAAA/10, 16'h5555/11 on consecutive cycles -> each word on its lane one cycle later, one valid_x per cycle, in_ready=1 throughout.
REQ-032 ready_b=0; send 16'h9876/01, then 16'h1111/01 -> first accepted, second stalls with in_ready=0, out_b=16'h9876 held; raise ready_b -> 16'h1111 accepted in the same cycle and appears on out_b next cycle.
REQ-033 Lane c FULL and stalled; send 16'h5555/11 -> accepted with in_ready=1 and delivered on lane d; lane c unchanged.
REQ-034 Lane a FULL with 16'hAAAA; assert reset for one cycle -> valid_a=0, out_a=16'h0000, word never delivered; next 16'h1234/00 delivered normally.
REQ-035 Back-to-back 16'h0001..16'h0008 all sel 10 with ready_c toggling every cycle -> out_c sequence exactly 0001..0008, no loss or repeat.
